// File: rtl/mem_unit_pkg.sv
// Shared types and constants for the program/data memory unit.
package mem_unit_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    RUN      = 3'd1,
    DUMP_RD  = 3'd2,
    DUMP_OUT = 3'd3,
    DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port word array: one write port and one registered read port.
module sp_ram
  import mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only moves on a read, so it holds between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_unit.sv
// CPU program/data memory: host load before the run, CPU access during it,
// and a host dump of a memory window once the CPU signals end of program.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 2**ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  cpu_rst_o,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_value_i,
  input  logic                  mem_enable_i,
  input  logic                  mem_wr_en_i,
  input  logic                  mem_rd_en_i,
  output logic [DATA_WIDTH-1:0] mem_value_o,
  input  logic                  end_program_i,
  output logic                  dump_valid_o,
  output logic [ADDR_WIDTH-1:0] dump_addr_o,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  input  logic                  dump_ready_i,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(DUMP_BASE);
  localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH+1)'(DUMP_WORDS - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   load_ptr;
  logic [ADDR_WIDTH:0]     dump_cnt;
  logic [ADDR_WIDTH-1:0]   dump_addr;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   hold_val;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic                    ram_we;
  logic                    ram_re;
  logic                    cpu_wr;
  logic                    cpu_rd;
  logic                    mem_view;

  assign rd_addr = BASE_ADDR + dump_cnt[ADDR_WIDTH-1:0];
  assign cpu_wr  = (state == RUN) && mem_enable_i && mem_wr_en_i;
  assign cpu_rd  = (state == RUN) && mem_enable_i && mem_rd_en_i && !mem_wr_en_i;

  // Route the single RAM port to the loader, the CPU or the dump reader.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = mem_addr_i;
    ram_wdata = mem_value_i;
    case (state)
      LOAD: begin
        ram_we    = load_valid_i;
        ram_addr  = load_ptr;
        ram_wdata = load_data_i;
      end
      RUN: begin
        ram_we = cpu_wr;
        ram_re = cpu_rd;
      end
      DUMP_RD: begin
        ram_re   = 1'b1;
        ram_addr = rd_addr;
      end
      default: begin
        ram_we = 1'b0;
        ram_re = 1'b0;
      end
    endcase
  end

  sp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Sequencer: load, run, alternate dump read/present, then park in DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= LOAD;
      load_ptr  <= '0;
      dump_cnt  <= '0;
      dump_addr <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid_i) begin
            if (load_last_i || (load_ptr == LAST_ADDR)) begin
              state <= RUN;
            end else begin
              load_ptr <= load_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        RUN: begin
          if (end_program_i) begin
            state <= DUMP_RD;
          end
        end
        DUMP_RD: begin
          dump_addr <= rd_addr;
          state     <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (dump_ready_i) begin
            dump_cnt <= dump_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (dump_cnt == LAST_CNT) begin
              state <= DONE;
            end else begin
              state <= DUMP_RD;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // The RAM read register carries the CPU result until the first dump read
  // replaces it; from then on the CPU sees the copy frozen in hold_val.
  always_comb begin
    if ((state == LOAD) || (state == RUN)) begin
      mem_view = 1'b1;
    end else if ((state == DUMP_RD) && (dump_cnt == '0)) begin
      mem_view = 1'b1;
    end else begin
      mem_view = 1'b0;
    end
  end

  // Snapshot of the last CPU read result, kept across the dump.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_val <= '0;
    end else if (mem_view) begin
      hold_val <= ram_rdata;
    end
  end

  assign mem_value_o  = mem_view ? ram_rdata : hold_val;
  assign cpu_rst_o    = (state != RUN);
  assign load_ready_o = (state == LOAD);
  assign dump_valid_o = (state == DUMP_OUT);
  assign dump_addr_o  = dump_addr;
  assign dump_data_o  = (state == DUMP_OUT) ? ram_rdata : '0;
  assign done_o       = (state == DONE);

endmodule
